iterative_alu: RTL and testbench

Arithmetic responder on the control-unit ALU handshake. It accepts a single-cycle request with a 2-bit opcode and two operands, then computes the result. ADD and SUB take one cycle. MUL (shift-add) and DIV (restoring) iterate over REG_SIZE cycles. It returns the result with a one-cycle done pulse.

---
 rtl/iterative_alu_if.sv | 41 ++++
 rtl/iterative_alu.sv | 173 +++++++++++++++++
 tb/tb_iterative_alu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/iterative_alu_if.sv
// ============================================================================
// Module      : iterative_alu_if
// Description : Control-unit <-> ALU request/response bundle. Flag signals
//               exist only when ALU_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iterative_alu_if #(
    parameter int REG_SIZE = 8
) ();
    logic [1:0]          alu_operation;
    logic [REG_SIZE-1:0] alu_op1;
    logic [REG_SIZE-1:0] alu_op2;
    logic                alu_req;
    logic                alu_done;
    logic [REG_SIZE-1:0] alu_res;
    logic                alu_busy;
`ifdef ALU_FLAGS_EN
    logic                alu_zero;
    logic                alu_carry;
`endif

    modport master (
        output alu_operation, alu_op1, alu_op2, alu_req,
`ifdef ALU_FLAGS_EN
        input  alu_zero, alu_carry,
`endif
        input  alu_done, alu_res, alu_busy
    );

    modport slave (
        input  alu_operation, alu_op1, alu_op2, alu_req,
`ifdef ALU_FLAGS_EN
        output alu_zero, alu_carry,
`endif
        output alu_done, alu_res, alu_busy
    );
endinterface

`default_nettype wire

// File: rtl/iterative_alu.sv
// ============================================================================
// Module      : iterative_alu
// Description : Handshaked ALU: single-cycle ADD/SUB, iterative shift-add MUL
//               and restoring DIV. Optional macro ALU_FLAGS_EN adds zero/carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_alu #(
    parameter int   REG_SIZE     = 8,
    parameter logic ACTIVE_RESET = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    iterative_alu_if.slave bus
);
    localparam int CW = $clog2(REG_SIZE + 1);
`ifdef ALU_FLAGS_EN
    localparam int ACC_W = 2 * REG_SIZE;
`else
    // Without flags the product's high half is never observable.
    localparam int ACC_W = REG_SIZE;
`endif

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ACC_W-1:0]    r_mcand;
    logic [ACC_W-1:0]    r_acc;
    logic [REG_SIZE-1:0] r_b;
    logic [REG_SIZE-1:0] r_rem;
    logic [REG_SIZE-1:0] r_quo;
    logic [CW-1:0]       r_cnt;
    logic [REG_SIZE-1:0] r_res;
    logic                r_done;
    logic                r_busy;

    logic [REG_SIZE-1:0] w_sum;
    logic [REG_SIZE-1:0] w_diff;
    logic [ACC_W-1:0]    w_acc_nx;
    logic [REG_SIZE:0]   w_rem_sh;
    logic                w_ge;
    logic [REG_SIZE-1:0] w_rem_sub;
    logic [REG_SIZE-1:0] w_rem_nx;
    logic [REG_SIZE-1:0] w_quo_nx;
    logic [REG_SIZE-1:0] w_calc_res;

`ifdef ALU_FLAGS_EN
    logic                w_add_c;
    logic                r_zero;
    logic                r_carry;
    assign {w_add_c, w_sum} = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
    assign bus.alu_zero  = r_zero;
    assign bus.alu_carry = r_carry;
`else
    assign w_sum = bus.alu_op1 + bus.alu_op2;
`endif
    assign w_diff = bus.alu_op1 - bus.alu_op2;

    assign w_acc_nx  = r_b[0] ? (r_acc + r_mcand) : r_acc;
    assign w_rem_sh  = {r_rem, r_quo[REG_SIZE-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    // Remainder after subtraction is below the divisor, so the low bits suffice.
    assign w_rem_sub = w_rem_sh[REG_SIZE-1:0] - r_b;
    assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[REG_SIZE-1:0];
    assign w_quo_nx  = {r_quo[REG_SIZE-2:0], w_ge};
    assign w_calc_res = (r_op == c_OP_MUL) ? w_acc_nx[REG_SIZE-1:0] : w_quo_nx;

    assign bus.alu_done = r_done;
    assign bus.alu_res  = r_res;
    assign bus.alu_busy = r_busy;

    always_ff @(posedge clk) begin
        if (rst == ACTIVE_RESET) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.alu_req) begin
                        r_op    <= bus.alu_operation;
                        r_mcand <= ACC_W'(bus.alu_op1);
                        r_b     <= bus.alu_op2;
                        r_quo   <= bus.alu_op1;
                        r_rem   <= '0;
                        r_acc   <= '0;
                        r_cnt   <= CW'(REG_SIZE);
                        r_busy  <= 1'b1;
                        if (bus.alu_operation == c_OP_ADD) begin
                            r_res   <= w_sum;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`ifdef ALU_FLAGS_EN
                            r_zero  <= (w_sum == '0);
                            r_carry <= w_add_c;
`endif
                        end else if (bus.alu_operation == c_OP_SUB) begin
                            r_res   <= w_diff;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`ifdef ALU_FLAGS_EN
                            r_zero  <= (w_diff == '0);
                            r_carry <= (bus.alu_op1 < bus.alu_op2);
`endif
                        end else if (bus.alu_operation == c_OP_DIV && bus.alu_op2 == '0) begin
                            r_res   <= '1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`ifdef ALU_FLAGS_EN
                            r_zero  <= 1'b0;
                            r_carry <= 1'b1;
`endif
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_nx;
                    r_mcand <= r_mcand << 1;
                    r_b     <= (r_op == c_OP_MUL) ? (r_b >> 1) : r_b;
                    r_rem   <= w_rem_nx;
                    r_quo   <= w_quo_nx;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_res   <= w_calc_res;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`ifdef ALU_FLAGS_EN
                        r_zero  <= (w_calc_res == '0);
                        r_carry <= (r_op == c_OP_MUL) ? (|w_acc_nx[ACC_W-1:REG_SIZE]) : 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iterative_alu.sv
// ============================================================================
// Module      : tb_iterative_alu
// Description : Scoreboard bench for iterative_alu with REG_SIZE=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_alu;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iterative_alu_if #(.REG_SIZE(N)) bus ();

    iterative_alu #(
        .REG_SIZE    (N),
        .ACTIVE_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string        name;
        logic [N-1:0] res;
        int           lat;
        logic         zero;
        logic         carry;
        int           issue;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [N-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst == 1'b0 && bus.alu_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_res"}, 32'(bus.alu_res), 32'(mon_e.res));
                    check({mon_e.name, "_lat"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
`ifdef ALU_FLAGS_EN
                    check({mon_e.name, "_zero"}, 32'(bus.alu_zero), 32'(mon_e.zero));
                    check({mon_e.name, "_carry"}, 32'(bus.alu_carry), 32'(mon_e.carry));
`endif
                    last_res = mon_e.res;
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] r, input int lat,
                         input logic z, input logic c, input bit push);
        exp_t ne;
        @(negedge clk);
        bus.alu_operation = op;
        bus.alu_op1       = a;
        bus.alu_op2       = b;
        bus.alu_req       = 1'b1;
        if (push) begin
            ne.name  = nm;
            ne.res   = r;
            ne.lat   = lat;
            ne.zero  = z;
            ne.carry = c;
            ne.issue = cyc;
            sb.push_back(ne);
        end
        @(negedge clk);
        bus.alu_req       = 1'b0;
        bus.alu_operation = 2'b11;
        bus.alu_op1       = 8'hA5;
        bus.alu_op2       = 8'h5A;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("hold_res", 32'(bus.alu_res), 32'(last_res));
        check("done_low", 32'(bus.alu_done), 32'd0);
    endtask

    initial begin
        int nb;
        bus.alu_req       = 1'b0;
        bus.alu_operation = 2'b00;
        bus.alu_op1       = '0;
        bus.alu_op2       = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_res",  32'(bus.alu_res),  32'd0);
        check("rst_busy", 32'(bus.alu_busy), 32'd0);
        check("rst_done", 32'(bus.alu_done), 32'd0);
        rst = 1'b0;

        issue("add_ovf", 2'b00, 8'd200, 8'd100, 8'd44,  1, 1'b0, 1'b1, 1'b1); drain();
        issue("sub_neg", 2'b01, 8'd5,   8'd7,   8'd254, 1, 1'b0, 1'b1, 1'b1); drain();
        issue("sub_eq",  2'b01, 8'd9,   8'd9,   8'd0,   1, 1'b1, 1'b0, 1'b1); drain();

        issue("mul_13x11", 2'b10, 8'd13, 8'd11, 8'd143, 9, 1'b0, 1'b0, 1'b1);
        nb = 0;
        for (int k = 1; k <= 9; k++) begin
            nb += int'(bus.alu_busy);
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(nb), 32'd9);
        check("mul_busy_after",  32'(bus.alu_busy), 32'd0);
        drain();

        issue("mul_20x20", 2'b10, 8'd20,  8'd20,  8'd144, 9, 1'b0, 1'b1, 1'b1); drain();
        issue("div_100_7", 2'b11, 8'd100, 8'd7,   8'd14,  9, 1'b0, 1'b0, 1'b1); drain();
        issue("div_zero",  2'b11, 8'd55,  8'd0,   8'd255, 1, 1'b0, 1'b1, 1'b1); drain();
        issue("div_small", 2'b11, 8'd7,   8'd100, 8'd0,   9, 1'b1, 1'b0, 1'b1); drain();

        // Request during CALC must be dropped.
        issue("mul_3x3", 2'b10, 8'd3, 8'd3, 8'd9, 9, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        bus.alu_operation = 2'b00;
        bus.alu_op1       = 8'd1;
        bus.alu_op2       = 8'd1;
        bus.alu_req       = 1'b1;
        @(negedge clk);
        bus.alu_req = 1'b0;
        drain();
        issue("add_1_1", 2'b00, 8'd1, 8'd1, 8'd2, 1, 1'b0, 1'b0, 1'b1); drain();

        // Reset in cycle 5 of a division aborts it.
        issue("div_abort", 2'b11, 8'd200, 8'd3, 8'd66, 9, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_res",  32'(bus.alu_res),  32'd0);
        check("abort_busy", 32'(bus.alu_busy), 32'd0);
        check("abort_done", 32'(bus.alu_done), 32'd0);
        last_res = '0;
        repeat (12) @(negedge clk);
        issue("add_1_2", 2'b00, 8'd1, 8'd2, 8'd3, 1, 1'b0, 1'b0, 1'b1); drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
